// File: rtl/tlu_pkg.sv
// Shared types for the TLU trigger recorder: word tags, FSM states and
// the capture record layout.
package tlu_pkg;

    localparam logic [3:0] TAG_W0 = 4'h8;
    localparam logic [3:0] TAG_W1 = 4'h1;
    localparam logic [3:0] TAG_W2 = 4'h2;
    localparam logic [3:0] TAG_W3 = 4'h3;

    localparam int REC_W = 104;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        W0   = 3'd1,
        W1   = 3'd2,
        W2   = 3'd3,
        W3   = 3'd4
    } state_t;

    typedef struct packed {
        logic [63:0] ts;
        logic [31:0] id;
        logic [7:0]  lost;
    } rec_t;

endpackage

// File: rtl/tlu_trig_record_buf.sv
// Capture buffer: small synchronous FIFO of trigger records.
// A push is accepted while full if a pop happens in the same cycle.
module tlu_trig_record_buf
    import tlu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     SYS_CLK,
    input  logic                     SYS_RST,
    input  logic                     push,
    input  logic                     pop,
    input  rec_t                     wdata,
    output rec_t                     head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    rec_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tlu_trig_recorder.sv
// Records accepted TLU triggers and streams each one out as four
// 32-bit FIFO words; counts triggers dropped on a full buffer.
module tlu_trig_recorder
    import tlu_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic        SYS_CLK,
    input  logic        SYS_RST,
    input  logic        ENABLE,
    input  logic        TRIG,
    input  logic [63:0] TIME_STAMP,
    input  logic [31:0] TRIG_ID,
    input  logic        FIFO_FULL,
    output logic        FIFO_WRITE,
    output logic [31:0] FIFO_DATA,
    output logic [7:0]  LOST_CNT,
    output logic        BUSY
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    state_t        state;
    state_t        state_nxt;
    rec_t          head;
    rec_t          rec_in;
    logic          buf_full;
    logic          buf_empty;
    logic [CW-1:0] buf_cnt;
    logic          trig_ok;
    logic          push;
    logic          pop;
    logic [31:0]   word;
    logic          unused_id_hi;

    assign trig_ok    = TRIG && ENABLE && !SYS_RST;
    assign FIFO_WRITE = (state != IDLE) && !FIFO_FULL && !SYS_RST;
    assign pop        = FIFO_WRITE && (state == W3);
    assign push       = trig_ok && (!buf_full || pop);
    assign rec_in     = {TIME_STAMP, TRIG_ID, LOST_CNT};
    assign BUSY       = !buf_empty || (state != IDLE);
    assign FIFO_DATA  = SYS_RST ? '0 : word;

    assign unused_id_hi = ^head.id[31:28];

    tlu_trig_record_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .SYS_CLK (SYS_CLK),
        .SYS_RST (SYS_RST),
        .push    (push),
        .pop     (pop),
        .wdata   (rec_in),
        .head    (head),
        .full    (buf_full),
        .empty   (buf_empty),
        .count   (buf_cnt)
    );

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next event follows W3 directly if one is still queued after the pop
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (!buf_empty) state_nxt = W0;
            W0:   if (FIFO_WRITE) state_nxt = W1;
            W1:   if (FIFO_WRITE) state_nxt = W2;
            W2:   if (FIFO_WRITE) state_nxt = W3;
            W3: begin
                if (FIFO_WRITE)
                    state_nxt = (buf_cnt > CW'(1) || push) ? W0 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        word = '0;
        unique case (state)
            W0:      word = {TAG_W0, head.id[27:0]};
            W1:      word = {TAG_W1, head.ts[27:0]};
            W2:      word = {TAG_W2, head.ts[55:28]};
            W3:      word = {TAG_W3, 12'h000, head.lost, head.ts[63:56]};
            default: word = '0;
        endcase
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST)
            LOST_CNT <= '0;
        else if (trig_ok && !push && LOST_CNT != 8'hFF)
            LOST_CNT <= LOST_CNT + 8'd1;
    end

endmodule

// File: tb/tb_tlu_trig_recorder.sv
// Directed bench for tlu_trig_recorder: latency, back-pressure,
// overflow, enable gating, saturation and reset behaviour.
module tb_tlu_trig_recorder;

    logic        SYS_CLK = 1'b0;
    logic        SYS_RST;
    logic        ENABLE;
    logic        TRIG;
    logic [63:0] TIME_STAMP;
    logic [31:0] TRIG_ID;
    logic        FIFO_FULL;
    logic        FIFO_WRITE;
    logic [31:0] FIFO_DATA;
    logic [7:0]  LOST_CNT;
    logic        BUSY;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] wq[$];
    int cq[$];

    tlu_trig_recorder #(.BUF_DEPTH(2)) dut (
        .SYS_CLK    (SYS_CLK),
        .SYS_RST    (SYS_RST),
        .ENABLE     (ENABLE),
        .TRIG       (TRIG),
        .TIME_STAMP (TIME_STAMP),
        .TRIG_ID    (TRIG_ID),
        .FIFO_FULL  (FIFO_FULL),
        .FIFO_WRITE (FIFO_WRITE),
        .FIFO_DATA  (FIFO_DATA),
        .LOST_CNT   (LOST_CNT),
        .BUSY       (BUSY)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    always @(posedge SYS_CLK) cyc++;

    always @(negedge SYS_CLK) begin
        if (FIFO_WRITE === 1'b1) begin
            wq.push_back(FIFO_DATA);
            cq.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge SYS_CLK);
            #1;
        end
    endtask

    task automatic smp;
        @(negedge SYS_CLK);
    endtask

    task automatic clr;
        wq.delete();
        cq.delete();
    endtask

    task automatic trig(input logic [63:0] ts, input logic [31:0] id);
        TRIG       = 1'b1;
        TIME_STAMP = ts;
        TRIG_ID    = id;
        step(1);
        TRIG = 1'b0;
    endtask

    function automatic logic [31:0] ew(input logic [63:0] ts,
                                       input logic [31:0] id,
                                       input logic [7:0] lost,
                                       input int k);
        logic [31:0] w;
        w = '0;
        case (k)
            0: w = {4'h8, id[27:0]};
            1: w = {4'h1, ts[27:0]};
            2: w = {4'h2, ts[55:28]};
            default: w = {4'h3, 12'h000, lost, ts[63:56]};
        endcase
        return w;
    endfunction

    function automatic logic [31:0] qw(input int i);
        return (i < wq.size()) ? wq[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic int qc(input int i);
        return (i < cq.size()) ? cq[i] : -1;
    endfunction

    task automatic chk_ev(input string tag, input int qi, input int c0,
                          input logic [63:0] ts, input logic [31:0] id,
                          input logic [7:0] lost);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_w%0d", tag, k), qw(qi + k), ew(ts, id, lost, k));
            chk($sformatf("%s_c%0d", tag, k), qc(qi + k), c0 + k);
        end
    endtask

    initial begin
        int t0;
        int t1;
        int r;
        SYS_RST    = 1'b1;
        ENABLE     = 1'b1;
        TRIG       = 1'b0;
        FIFO_FULL  = 1'b0;
        TIME_STAMP = '0;
        TRIG_ID    = '0;

        // reset
        step(2);
        smp;
        chk("rst_wr", FIFO_WRITE, 1'b0);
        chk("rst_data", FIFO_DATA, 32'h0);
        step(1);
        SYS_RST = 1'b0;
        smp;
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_lost", LOST_CNT, 8'h00);
        chk("idle_data", FIFO_DATA, 32'h0);

        // single event
        step(1);
        clr();
        t0 = cyc;
        trig(64'h0123_4567_89AB_CDEF, 32'h0000_0005);
        step(5);
        smp;
        chk("s_busy", BUSY, 1'b0);
        chk("s_n", wq.size(), 4);
        chk("s_w0", qw(0), 32'h8000_0005);
        chk("s_w1", qw(1), 32'h19AB_CDEF);
        chk("s_w2", qw(2), 32'h2234_5678);
        chk("s_w3", qw(3), 32'h3000_0001);
        chk("s_c0", qc(0), t0 + 2);
        chk("s_c3", qc(3), t0 + 5);

        // back-pressure during W1
        step(1);
        clr();
        t0 = cyc;
        trig(64'hFEDC_BA98_7654_3210, 32'hABCD_1234);
        step(2);
        FIFO_FULL = 1'b1;
        step(2);
        smp;
        chk("bp_hold_wr", FIFO_WRITE, 1'b0);
        chk("bp_hold_data", FIFO_DATA, 32'h1654_3210);
        step(3);
        FIFO_FULL = 1'b0;
        step(3);
        smp;
        chk("bp_n", wq.size(), 4);
        chk("bp_w0", qw(0), 32'h8BCD_1234);
        chk("bp_w1", qw(1), 32'h1654_3210);
        chk("bp_w2", qw(2), 32'h2DCB_A987);
        chk("bp_w3", qw(3), 32'h3000_00FE);
        chk("bp_c0", qc(0), t0 + 2);
        chk("bp_c1", qc(1), t0 + 8);
        chk("bp_c3", qc(3), t0 + 10);

        // overflow with a stalled FIFO
        step(1);
        clr();
        FIFO_FULL = 1'b1;
        trig(64'h1111_2222_3333_4444, 32'h1);
        step(1);
        trig(64'h5555_6666_7777_8888, 32'h2);
        for (int i = 0; i < 3; i++) begin
            step(1);
            trig(64'h9999_0000_0000_0000, 32'h9);
        end
        smp;
        chk("ov_lost", LOST_CNT, 8'd3);
        chk("ov_busy", BUSY, 1'b1);
        chk("ov_wr", FIFO_WRITE, 1'b0);
        step(1);
        r = cyc;
        FIFO_FULL = 1'b0;
        step(9);
        smp;
        chk("ov_n", wq.size(), 8);
        chk_ev("ov_e1", 0, r, 64'h1111_2222_3333_4444, 32'h1, 8'd0);
        chk_ev("ov_e2", 4, r + 4, 64'h5555_6666_7777_8888, 32'h2, 8'd0);
        chk("ov_lost2", LOST_CNT, 8'd3);
        chk("ov_busy2", BUSY, 1'b0);

        // enable low ignores triggers
        step(1);
        clr();
        ENABLE = 1'b0;
        trig(64'h0000_0000_0000_0ABC, 32'h77);
        step(6);
        smp;
        chk("en_n", wq.size(), 0);
        chk("en_busy", BUSY, 1'b0);
        chk("en_lost", LOST_CNT, 8'd3);
        step(1);
        ENABLE = 1'b1;

        // trigger in the W3 cycle of a full buffer
        clr();
        FIFO_FULL = 1'b1;
        trig(64'hA000_0000_0000_0003, 32'h3);
        step(1);
        trig(64'hB000_0000_0000_0004, 32'h4);
        step(1);
        r = cyc;
        FIFO_FULL = 1'b0;
        step(3);
        trig(64'hC000_0000_0000_0005, 32'h5);
        step(8);
        smp;
        chk("pp_n", wq.size(), 12);
        chk("pp_lost", LOST_CNT, 8'd3);
        chk_ev("pp_e3", 0, r, 64'hA000_0000_0000_0003, 32'h3, 8'd3);
        chk_ev("pp_e4", 4, r + 4, 64'hB000_0000_0000_0004, 32'h4, 8'd3);
        chk_ev("pp_e5", 8, r + 8, 64'hC000_0000_0000_0005, 32'h5, 8'd3);
        chk("pp_busy", BUSY, 1'b0);

        // saturation of the lost counter
        step(1);
        FIFO_FULL = 1'b1;
        trig(64'h1, 32'h6);
        step(1);
        trig(64'h2, 32'h7);
        TRIG = 1'b1;
        step(300);
        TRIG = 1'b0;
        smp;
        chk("sat_lost", LOST_CNT, 8'hFF);
        step(1);
        SYS_RST = 1'b1;
        step(1);
        SYS_RST   = 1'b0;
        FIFO_FULL = 1'b0;
        smp;
        chk("sat_rst_lost", LOST_CNT, 8'h00);
        chk("sat_rst_busy", BUSY, 1'b0);

        // reset while in W2, with a coincident trigger
        step(1);
        clr();
        t0 = cyc;
        trig(64'hDDDD_EEEE_FFFF_0123, 32'h0000_0042);
        step(3);
        SYS_RST    = 1'b1;
        TRIG       = 1'b1;
        TIME_STAMP = 64'h5;
        TRIG_ID    = 32'h5;
        smp;
        chk("mr_wr", FIFO_WRITE, 1'b0);
        chk("mr_data", FIFO_DATA, 32'h0);
        step(1);
        SYS_RST = 1'b0;
        TRIG    = 1'b0;
        smp;
        chk("mr_busy", BUSY, 1'b0);
        chk("mr_lost", LOST_CNT, 8'h00);
        step(1);
        t1 = cyc;
        trig(64'h0000_0000_1234_5678, 32'h0000_0099);
        step(6);
        smp;
        chk("mr_n", wq.size(), 6);
        chk("mr_w0", qw(0), 32'h8000_0042);
        chk("mr_w1", qw(1), 32'h1FFF_0123);
        chk("mr_c1", qc(1), t0 + 3);
        chk_ev("mr_e9", 2, t1 + 2, 64'h0000_0000_1234_5678, 32'h99, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
